// File: rtl/alu_pkg.sv
// Shared definitions for the ALU write-back stage: op codes, flag bit
// positions, the stored entry layout and the flag-formation rule.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_NOR = 3'b101,
    OP_SLT = 3'b110,
    OP_BEQ = 3'b111
  } op_e;

  localparam int unsigned FLAGS_W    = 4;
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OV    = 2;
  localparam int unsigned FLAG_EQ    = 3;

  typedef struct packed {
    logic [31:0]        c;
    logic [4:0]         rd;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // eq only for a BEQ whose result is all ones; overflow/carry only
  // meaningful for ADD/SUB; zero is passed straight through.
  function automatic logic [FLAGS_W-1:0] form_flags(
    input op_e         op,
    input logic [31:0] c,
    input logic        zero,
    input logic        overflow,
    input logic        carry
  );
    logic [FLAGS_W-1:0] f;
    logic               arith;
    f             = '0;
    arith         = (op == OP_ADD) || (op == OP_SUB);
    f[FLAG_EQ]    = (op == OP_BEQ) && (c == '1);
    f[FLAG_OV]    = arith && overflow;
    f[FLAG_CARRY] = arith && carry;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Two-entry FIFO holding write-back entries. Control state is reset;
// the data storage is not.
module alu_wb_fifo
  import alu_pkg::*;
#(
  parameter int unsigned W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // Data storage write; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; single-bit pointers wrap modulo 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head view and status, all from registered state.
  always_comb begin
    rdata = mem[rd_ptr];
    full  = (count == 2'd2);
    empty = (count == 2'd0);
  end

endmodule

// File: rtl/alu_wb.sv
// ALU write-back stage: forms stored flags, drops NOPs, buffers results
// in a 2-entry FIFO and accumulates sticky overflow/carry status.
// Optional feature macro: ALU_WB_STICKY_EN (sticky status logic).
module alu_wb
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_c,
  input  logic        in_zero,
  input  logic        in_overflow,
  input  logic        in_carry_out,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [4:0]  out_rd,
  output logic [3:0]  out_flags,
  input  logic        clr_sticky,
  output logic        sticky_ov,
  output logic        sticky_cy
);

  entry_t wr_entry;
  entry_t head;
  logic   fifo_push;
  logic   pop;
  logic   full;
  logic   empty;

  // Entry formation and handshakes; a NOP is accepted but never written.
  always_comb begin
    wr_entry.c     = in_c;
    wr_entry.rd    = in_rd;
    wr_entry.flags = form_flags(op_e'(in_op), in_c, in_zero, in_overflow, in_carry_out);
    in_ready       = !full;
    out_valid      = !empty;
    fifo_push      = in_valid && in_ready && (op_e'(in_op) != OP_NOP);
    pop            = out_valid && out_ready;
  end

  alu_wb_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Head entry presented downstream.
  always_comb begin
    out_c     = head.c;
    out_rd    = head.rd;
    out_flags = head.flags;
  end

`ifdef ALU_WB_STICKY_EN
  logic set_ov;
  logic set_cy;

  // Set terms come from the entry leaving the FIFO this cycle.
  always_comb begin
    set_ov = pop && head.flags[FLAG_OV];
    set_cy = pop && head.flags[FLAG_CARRY];
  end

  // OR-accumulate; a coincident set overrides the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ov <= 1'b0;
      sticky_cy <= 1'b0;
    end else begin
      sticky_ov <= (sticky_ov && !clr_sticky) || set_ov;
      sticky_cy <= (sticky_cy && !clr_sticky) || set_cy;
    end
  end
`else
  logic unused_clr;

  // Sticky status absent in this build.
  always_comb begin
    sticky_ov  = 1'b0;
    sticky_cy  = 1'b0;
    unused_clr = clr_sticky;
  end
`endif

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue model.
module tb_alu_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_c;
  logic        in_zero;
  logic        in_overflow;
  logic        in_carry_out;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [4:0]  out_rd;
  logic [3:0]  out_flags;
  logic        clr_sticky;
  logic        sticky_ov;
  logic        sticky_cy;

  int checks;
  int failures;

`ifdef ALU_WB_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  alu_wb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_c         (in_c),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_carry_out (in_carry_out),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_c        (out_c),
    .out_rd       (out_rd),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_ov    (sticky_ov),
    .sticky_cy    (sticky_cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_op        = 3'b000;
    in_c         = '0;
    in_zero      = 1'b0;
    in_overflow  = 1'b0;
    in_carry_out = 1'b0;
    in_rd        = '0;
    out_ready    = 1'b0;
    clr_sticky   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] c, input logic [4:0] rd,
                       input logic ov, input logic cy, input logic z);
    in_valid     = 1'b1;
    in_op        = op;
    in_c         = c;
    in_rd        = rd;
    in_overflow  = ov;
    in_carry_out = cy;
    in_zero      = z;
  endtask

  // Reference flag rule: {eq, overflow, carry, zero}.
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [31:0] c,
                                           input logic ov, input logic cy, input logic z);
    logic arith;
    arith = (op == 3'd1) || (op == 3'd2);
    return {(op == 3'd7) && (c == 32'hFFFF_FFFF), arith & ov, arith & cy, z};
  endfunction

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] c;
    logic [4:0]  rd;
    logic        ov;
    logic        cy;
    logic        z;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [9];

  typedef struct packed {
    logic [31:0] c;
    logic [4:0]  rd;
    logic [3:0]  flags;
  } mentry_t;

  mentry_t q[$];
  logic    m_sov, m_scy;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    idle_inputs();

    vecs[0] = '{3'b001, 32'h0000_0005, 5'd3,  1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{3'b111, 32'hFFFF_FFFF, 5'd7,  1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[2] = '{3'b111, 32'hFFFF_FFFE, 5'd8,  1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[3] = '{3'b011, 32'h0000_00F0, 5'd9,  1'b1, 1'b1, 1'b1, 4'b0001};
    vecs[4] = '{3'b010, 32'h8000_0000, 5'd10, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[5] = '{3'b001, 32'h0000_0000, 5'd11, 1'b0, 1'b1, 1'b1, 4'b0011};
    vecs[6] = '{3'b110, 32'h0000_0001, 5'd12, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[7] = '{3'b111, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[8] = '{3'b100, 32'h0000_0000, 5'd31, 1'b0, 0,    1'b1, 4'b0001};

    // Reset state.
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_sticky_ov", sticky_ov, 0);
    chk("rst_sticky_cy", sticky_cy, 0);

    // Single-entry vectors with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].op, vecs[i].c, vecs[i].rd, vecs[i].ov, vecs[i].cy, vecs[i].z);
      cyc();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_c", i),     out_c,     vecs[i].c);
      chk($sformatf("vec%0d_rd", i),    out_rd,    vecs[i].rd);
      chk($sformatf("vec%0d_flags", i), out_flags, vecs[i].flags);
      cyc();
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Back-pressure: third push held, head stable, count pinned at 2.
    do_reset();
    drive(3'b001, 32'hA1, 5'd1, 0, 0, 0);
    cyc();
    chk("bp1_ready", in_ready, 1);
    chk("bp1_c", out_c, 32'hA1);
    in_c = 32'hA2; in_rd = 5'd2;
    cyc();
    chk("bp2_ready", in_ready, 0);
    chk("bp2_c", out_c, 32'hA1);
    in_c = 32'hA3; in_rd = 5'd3;
    cyc();
    chk("bp3_ready", in_ready, 0);
    chk("bp3_c", out_c, 32'hA1);
    chk("bp3_rd", out_rd, 5'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp4_c", out_c, 32'hA2);
    chk("bp4_ready", in_ready, 1);
    cyc();
    chk("bp5_empty", out_valid, 0);

    // Simultaneous push and pop with one entry resident.
    drive(3'b001, 32'hB1, 5'd4, 0, 0, 0);
    cyc();
    chk("pp1_c", out_c, 32'hB1);
    in_c = 32'hB2; in_rd = 5'd5;
    cyc();
    in_valid = 1'b0;
    chk("pp2_valid", out_valid, 1);
    chk("pp2_c", out_c, 32'hB2);
    chk("pp2_ready", in_ready, 1);
    cyc();
    chk("pp3_empty", out_valid, 0);

    // NOP is accepted but dropped.
    do_reset();
    drive(3'b000, 32'hDEAD, 5'd6, 1, 1, 1);
    chk("nop_ready", in_ready, 1);
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("nop_valid", out_valid, 0);
    chk("nop_ready2", in_ready, 1);

    // Sticky set, set-beats-clear, then clear alone.
    do_reset();
    out_ready = 1'b1;
    drive(3'b010, 32'h1, 5'd1, 1, 0, 0);
    cyc();
    in_valid = 1'b0;
    chk("stk_pre", sticky_ov, 0);
    cyc();
    chk("stk_set_ov", sticky_ov, STK);
    drive(3'b010, 32'h2, 5'd2, 1, 0, 0);
    cyc();
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    cyc();
    chk("stk_set_wins", sticky_ov, STK);
    cyc();
    clr_sticky = 1'b0;
    chk("stk_clr", sticky_ov, 0);
    drive(3'b001, 32'h3, 5'd3, 0, 1, 0);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("stk_set_cy", sticky_cy, STK);
    chk("stk_ov_quiet", sticky_ov, 0);

    // Reset while full drops everything.
    out_ready = 1'b0;
    drive(3'b010, 32'h4, 5'd4, 1, 1, 0);
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("full_before_rst", in_ready, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_ready", in_ready, 1);
    chk("rst_full_sov", sticky_ov, 0);
    chk("rst_full_scy", sticky_cy, 0);

    // Randomized traffic against the queue model.
    do_reset();
    q.delete();
    m_sov = 1'b0;
    m_scy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic    acc, pop, set_ov, set_cy;
      logic [2:0] op;
      mentry_t e;
      op = 3'($urandom_range(0, 7));
      drive(op, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
            5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      acc    = in_valid && (q.size() < 2);
      pop    = (q.size() != 0) && out_ready;
      set_ov = pop && q[0].flags[2];
      set_cy = pop && q[0].flags[1];
      e.c     = in_c;
      e.rd    = in_rd;
      e.flags = ref_flags(op, in_c, in_overflow, in_carry_out, in_zero);
      cyc();
      if (pop) void'(q.pop_front());
      if (acc && op != 3'd0) q.push_back(e);
      m_sov = STK && ((m_sov && !clr_sticky) || set_ov);
      m_scy = STK && ((m_scy && !clr_sticky) || set_cy);
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
        chk("rnd_c", out_c, q[0].c);
        chk("rnd_rd", out_rd, q[0].rd);
        chk("rnd_flags", out_flags, q[0].flags);
      end
      chk("rnd_sov", sticky_ov, m_sov);
      chk("rnd_scy", sticky_cy, m_scy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
